// File: rtl/instr_mem_loader.sv
// Streams 24-bit instruction words into a byte-wide instruction memory,
// writing each word as three big-endian bytes at consecutive addresses.
module instr_mem_loader #(
  parameter int ADDR_W     = 24,
  parameter int MEM_BYTES  = 128,
  parameter int START_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [23:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WR0,
    S_WR1,
    S_WR2,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W:0]   LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [23:0]       word_reg;
  logic              last_reg;
  logic              word_fits;

  // One extra bit so a pointer near the top of the address space cannot wrap past the check.
  assign word_fits = ({1'b0, ptr_reg} + (ADDR_W+1)'(2)) <= LAST_BYTE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= START_PTR;
      word_reg   <= '0;
      last_reg   <= 1'b0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_reg  <= S_ACCEPT;
            ptr_reg    <= START_PTR;
            word_count <= '0;
            busy       <= 1'b1;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            word_ready <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (start) begin
            // Restart takes precedence over a same-cycle handshake.
            ptr_reg    <= START_PTR;
            word_count <= '0;
            word_ready <= 1'b0;
          end else if (word_ready && word_valid) begin
            word_ready <= 1'b0;
            if (word_fits) begin
              state_reg <= S_WR0;
              word_reg  <= word_data;
              last_reg  <= word_last;
              mem_we    <= 1'b1;
              mem_addr  <= ptr_reg;
              mem_data  <= word_data[23:16];
            end else begin
              state_reg <= S_ERROR;
              overflow  <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            word_ready <= 1'b1;
          end
        end
        S_WR0: begin
          state_reg <= S_WR1;
          mem_addr  <= ptr_reg + ADDR_W'(1);
          mem_data  <= word_reg[15:8];
        end
        S_WR1: begin
          state_reg <= S_WR2;
          mem_addr  <= ptr_reg + ADDR_W'(2);
          mem_data  <= word_reg[7:0];
        end
        S_WR2: begin
          mem_we  <= 1'b0;
          ptr_reg <= ptr_reg + ADDR_W'(3);
          if (word_count != 16'hFFFF) begin
            word_count <= word_count + 16'd1;
          end
          if (last_reg) begin
            state_reg <= S_DONE;
            load_done <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state_reg  <= S_ACCEPT;
            word_ready <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader, checked every cycle against a
// queue-based model of the expected byte-write schedule and session flags.
module tb_instr_mem_loader;

  localparam int ADDR_W    = 24;
  localparam int MEM_BYTES = 128;
  localparam int START     = 0;

  logic              clk = 1'b0;
  logic              reset, start, word_valid, word_last;
  logic [23:0]       word_data;
  logic              word_ready, mem_we, busy, load_done, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [15:0]       word_count;

  instr_mem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .START_ADDR(START)) dut (
    .clock(clk), .reset(reset), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
    .load_done(load_done), .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: session flags plus a queue of byte writes still to appear on the port.
  int          m_ptr, m_count;
  bit          m_session, m_inflight, m_last, m_ready, m_we, m_busy, m_done, m_ovf;
  logic [23:0] m_addr;
  logic [7:0]  m_data;
  logic [31:0] sched[$];
  bit          hs;

  logic [24:0] src_q[$];
  bit          dense;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pop_write();
    logic [31:0] e;
    e = sched.pop_front();
    m_addr = e[31:8];
    m_data = e[7:0];
    m_we   = 1'b1;
  endtask

  task automatic model_edge();
    hs = 1'b0;
    if (reset) begin
      m_ptr = START; m_count = 0; m_session = 0; m_inflight = 0; m_last = 0;
      m_ready = 0; m_we = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_addr = '0; m_data = '0;
      sched.delete();
    end else if (m_inflight) begin
      if (sched.size() > 0) begin
        pop_write();
      end else begin
        m_inflight = 0;
        m_we = 0;
        if (m_count < 65535) m_count++;
        m_ptr += 3;
        if (m_last) begin
          m_done = 1; m_busy = 0; m_session = 0;
        end else begin
          m_ready = 1;
        end
      end
    end else if (start) begin
      m_ready   = !m_session;
      m_session = 1;
      m_ptr = START; m_count = 0; m_busy = 1; m_done = 0; m_ovf = 0;
    end else if (m_session && m_ready && word_valid) begin
      hs = 1'b1;
      m_ready = 0;
      if (m_ptr + 2 <= MEM_BYTES - 1) begin
        for (int b = 0; b < 3; b++)
          sched.push_back({24'(m_ptr + b), word_data[23-8*b -: 8]});
        pop_write();
        m_inflight = 1;
        m_last = word_last;
      end else begin
        m_ovf = 1; m_busy = 0; m_session = 0;
      end
    end else if (m_session) begin
      m_ready = 1;
    end
  endtask

  task automatic drive_source();
    if (src_q.size() == 0) begin
      word_valid = 1'b0;
      word_data  = 24'($urandom);
      word_last  = 1'($urandom);
    end else if (hs || !word_valid) begin
      word_valid = dense || ($urandom_range(0, 2) != 0);
      word_data  = src_q[0][23:0];
      word_last  = src_q[0][24];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (hs) begin
      $display("word accepted data=%h last=%0b ptr=%0d", word_data, word_last, m_ptr);
      void'(src_q.pop_front());
    end
    check("mem_we", 32'(mem_we), 32'(m_we));
    check("word_ready", 32'(word_ready), 32'(m_ready));
    check("busy", 32'(busy), 32'(m_busy));
    check("load_done", 32'(load_done), 32'(m_done));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("word_count", 32'(word_count), 32'(m_count));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_data", 32'(mem_data), 32'(m_data));
    start = 1'b0;
    drive_source();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [23:0] d, input logic l);
    src_q.push_back({l, d});
    drive_source();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
    dense = 1'b1;
    run(2);
    reset = 1'b0;

    // Word pending with no Start: nothing may happen.
    push(24'hA1B2C3, 1'b1);
    run(8);
    start = 1'b1;
    run(10);

    // Three back-to-back words.
    push(24'h111111, 1'b0); push(24'h222222, 1'b0); push(24'h333333, 1'b1);
    start = 1'b1;
    run(16);

    // Fill memory then overflow on word 43.
    for (int i = 0; i < 43; i++) push(24'($urandom), 1'b0);
    start = 1'b1;
    run(43 * 4 + 4);
    check("overflow_reached", 32'(overflow), 32'd1);
    start = 1'b1;
    run(3);
    push(24'h5A5A5A, 1'b1);
    run(8);

    // Reset in WR1.
    push(24'hDEADBE, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 40 && !(m_inflight && sched.size() == 1); i++) tick();
    check("reach_wr1", 32'(m_inflight && sched.size() == 1), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src_q.delete();
    drive_source();
    push(24'h0F1E2D, 1'b1);
    start = 1'b1;
    run(10);

    // Start during WR0 of word 2, then restart in ACCEPT before word 3.
    push(24'h123456, 1'b0); push(24'h789ABC, 1'b0); push(24'hCAFE01, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 40 && !(m_count == 1 && m_inflight && sched.size() == 2); i++) tick();
    check("reach_wr0_w2", 32'(m_count == 1 && m_inflight && sched.size() == 2), 32'd1);
    start = 1'b1;
    tick();
    for (int i = 0; i < 40 && !(m_count == 2 && !m_inflight); i++) tick();
    check("reach_accept_w3", 32'(m_count == 2 && !m_inflight), 32'd1);
    start = 1'b1;
    run(12);

    // Randomized sessions, stalls, restarts and resets.
    dense = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (src_q.size() == 0 && $urandom_range(0, 19) == 0) begin
        int n;
        n = $urandom_range(1, 8);
        for (int k = 0; k < n; k++) push(24'($urandom), k == n - 1);
      end
      if ($urandom_range(0, 59) == 0) start = 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Write-side companion to the byte-wide, big-endian 24-bit instruction memory. It accepts 24-bit instruction words over a valid/ready stream and performs three sequential byte writes per word. The write order is MSB first, at consecutive addresses starting from a load base. It sits between a host/boot source and the instruction memory write port, and holds Busy high so the CPU stays in reset until the program image is loaded.

Parameters:
ADDR_W, 24, width of the byte address (matches PC width)
MEM_BYTES, 128, instruction memory size in bytes; highest legal byte address is MEM_BYTES-1
START_ADDR, 0, byte address of the first word written after Start

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle pulse; opens a load session and sets the write pointer to START_ADDR
WordValid  input  1  source has a word on WordData
WordData  input  24  instruction word; [23:16] goes to the lowest address
WordLast  input  1  qualifies WordData as the final word of the image
WordReady  output  1  loader can accept a word this cycle
MemWE  output  1  byte write enable to the instruction memory
MemAddr  output  ADDR_W  byte write address
MemData  output  8  byte write data
Busy  output  1  session active (from Start until DONE or ERROR)
LoadDone  output  1  sticky; image fully written
Overflow  output  1  sticky; a word would exceed MEM_BYTES
WordCount  output  16  words fully written in the current session

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything. State=IDLE. All outputs are 0: WordReady, MemWE, MemAddr, MemData, Busy, LoadDone, Overflow, WordCount. Ptr=START_ADDR.
- Reset asserted mid-write aborts immediately. MemWE is 0 from the next edge. The partial word stays partial in memory; the loader does not clean it up.
- All outputs are registered. WordReady=1 only in ACCEPT.
- IDLE:
  - Start -> ACCEPT.
  - Ptr=START_ADDR; Busy=1; LoadDone=0; Overflow=0; WordCount=0.
- ACCEPT: handshake is WordValid&&WordReady at a rising edge.
  - If Ptr+2 <= MEM_BYTES-1: latch WordData and WordLast, then go to WR0.
  - Else go to ERROR. No write occurs.
  - The address compare uses ADDR_W+1 bits, so Ptr near 2^ADDR_W cannot wrap and pass the check.
  - Start in ACCEPT restarts the session: Ptr=START_ADDR, WordCount=0. Any handshake in that same cycle is ignored. WordReady drops for one cycle.
- WR0/WR1/WR2: one byte per cycle, MemWE=1 in all three.
  - WR0: MemAddr=Ptr, MemData=word[23:16].
  - WR1: MemAddr=Ptr+1, MemData=word[15:8].
  - WR2: MemAddr=Ptr+2, MemData=word[7:0].
  - Start is ignored in these states; a word is never split across a restart.
- Leaving WR2: Ptr+=3 and WordCount+=1.
  - If the latched Last=1, go to DONE.
  - Else go to ACCEPT.
- Latency: handshake at edge k gives MemWE high during cycles k+1..k+3.
  - Earliest next handshake is edge k+4, so throughput is 1 word per 4 cycles.
- DONE:
  - LoadDone=1, Busy=0, MemWE=0.
  - Start -> ACCEPT with a fresh session, which clears LoadDone.
- ERROR:
  - Overflow=1, Busy=0, WordReady=0, MemWE=0. WordCount holds.
  - Only Start or Reset leaves this state. Start goes to ACCEPT and clears Overflow.
- MemAddr and MemData hold their last values when MemWE=0. Consumers qualify them with MemWE only.
- WordCount saturates at 16'hFFFF. This is unreachable with the default MEM_BYTES.
- Words that are valid outside ACCEPT stay pending; the source must hold WordData until the handshake.

Test Plan:
- Reset then Start, then one word 24'hA1B2C3 with Last=1:
  - MemWE cycles write (0,A1), (1,B2), (2,C3).
  - Then LoadDone=1, Busy=0, WordCount=1.
- Three back-to-back words 24'h111111, 24'h222222, 24'h333333 (Last on the third):
  - Writes to addresses 0-8 in order.
  - WordReady gaps are exactly 3 cycles.
  - WordCount=3.
- MEM_BYTES=128, stream 43 words:
  - Words 1-42 write addresses 0-125.
  - Word 43 (Ptr=126): no MemWE, Overflow=1, WordCount=42.
  - Start then clears Overflow.
- Reset asserted in WR1 of word 24'hDEADBE:
  - Next cycle MemWE=0, all outputs 0.
  - A new Start and word writes from address 0.
- Start pulsed during WR0 of the second word:
  - The word completes at addresses 3-5; Start is ignored.
  - Start pulsed later in ACCEPT: the next word lands at address 0 and WordCount=0 before it.
- WordValid held high with Start never pulsed:
  - WordReady stays 0, no writes, Busy=0.
